// File: rtl/down_counter_timer.sv
// Loadable countdown timer with an internal prescaler and a start/pause/load FSM.
// Optional macro AUTO_RELOAD_EN: reload from the reload register instead of stopping at zero.
module down_counter_timer #(
  parameter logic [28:0] DIVISOR = 29'd200000000,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] counter_out,
  output logic             tick_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [28:0]      PRESC_MAX = DIVISOR - 29'd1;
  localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [28:0]      r_presc;
  logic [28:0]      w_presc_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             r_tick;
  logic             r_busy;
  logic             r_done;
  logic             w_tick_nxt;
  logic             w_done_pulse;
  logic             w_wrap;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  assign w_wrap = (r_presc == PRESC_MAX);

  // Next-state, prescaler, count and reload decode; load overrides everything but reset.
  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_tick_nxt   = 1'b0;
    w_done_pulse = 1'b0;
    if (load) begin
      w_count_nxt  = load_value;
      w_reload_nxt = load_value;
      w_presc_nxt  = 29'd0;
      w_state_nxt  = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_presc_nxt = 29'd0;
            if (r_count != CNT_ZERO) begin
              w_state_nxt = S_RUN;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_RUN: begin
          // A pause on a tick edge still takes the decrement; reaching zero beats pausing.
          if (w_wrap) begin
            w_presc_nxt = 29'd0;
            w_tick_nxt  = 1'b1;
            if (r_count == CNT_ONE) begin
`ifdef AUTO_RELOAD_EN
              if (r_reload != CNT_ZERO) begin
                w_count_nxt  = r_reload;
                w_done_pulse = 1'b1;
                w_state_nxt  = pause ? S_PAUSED : S_RUN;
              end else begin
                w_count_nxt = CNT_ZERO;
                w_state_nxt = S_DONE;
              end
`else
              w_count_nxt = CNT_ZERO;
              w_state_nxt = S_DONE;
`endif
            end else if (r_count == CNT_ZERO) begin
              w_count_nxt = CNT_ZERO;
              w_state_nxt = S_DONE;
            end else begin
              w_count_nxt = r_count - CNT_ONE;
              w_state_nxt = pause ? S_PAUSED : S_RUN;
            end
          end else begin
            w_presc_nxt = r_presc + 29'd1;
            w_state_nxt = pause ? S_PAUSED : S_RUN;
          end
        end
        S_PAUSED: begin
          if (start) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_PAUSED;
          end
        end
        S_DONE: begin
          w_count_nxt = CNT_ZERO;
          if (start && (r_reload != CNT_ZERO)) begin
            w_count_nxt = r_reload;
            w_presc_nxt = 29'd0;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        default: begin
          w_count_nxt = CNT_ZERO;
          w_presc_nxt = 29'd0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded from the upcoming state so they change on the same edge.
  always_comb begin
    w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSED);
    w_done_nxt = (w_state_nxt == S_DONE) || w_done_pulse;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_presc  <= 29'd0;
      r_count  <= CNT_ZERO;
      r_reload <= CNT_ZERO;
      r_tick   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_tick   <= w_tick_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign counter_out = r_count;
  assign tick_out    = r_tick;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
